// File: rtl/ascii_arb_pkg.sv
// Shared state encoding and ASCII constants for the ASCII stream arbiter.
// The prefix states are only reachable when ASCII_ARB_PREFIX_EN is defined.
package ascii_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PFX_ID    = 2'd1,
    ST_PFX_COLON = 2'd2,
    ST_LOCKED    = 2'd3
  } arb_state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_DEL   = 8'h7F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // A line ends on LF or ESC; every other code, DEL included, is payload.
  function automatic logic is_eol(input logic [7:0] chr);
    return (chr == ASCII_LF) || (chr == ASCII_ESC);
  endfunction

endpackage

// File: rtl/ascii_rr_picker.sv
// Combinational round-robin pick: first valid requester at or above the
// pointer, wrapping at p_num_reqs.
module ascii_rr_picker #(
  parameter int p_num_reqs = 2,
  parameter int p_idx_w    = $clog2(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] req_val,
  input  logic [p_idx_w-1:0]    pointer,
  output logic [p_idx_w-1:0]    winner,
  output logic                  any_val
);

  logic [p_idx_w:0]   sum_s;
  logic [p_idx_w-1:0] idx_s;

  // Search upward from the pointer; the first hit wins.
  always_comb begin
    winner  = pointer;
    any_val = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      sum_s = {1'b0, pointer} + (p_idx_w + 1)'(i);
      if (sum_s >= (p_idx_w + 1)'(p_num_reqs)) begin
        idx_s = p_idx_w'(sum_s - (p_idx_w + 1)'(p_num_reqs));
      end else begin
        idx_s = p_idx_w'(sum_s);
      end
      if (!any_val && req_val[idx_s]) begin
        any_val = 1'b1;
        winner  = idx_s;
      end else begin
        any_val = any_val;
      end
    end
  end

endmodule

// File: rtl/ascii_stream_arb.sv
// Line-locked round-robin arbiter merging ASCII requesters into one stream.
// Define ASCII_ARB_PREFIX_EN to prepend "<id>:" to every granted line.
module ascii_stream_arb
  import ascii_arb_pkg::*;
#(
  parameter int p_num_reqs = 2,
  parameter int p_timeout  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [p_num_reqs-1:0][7:0]    req_ascii,
  input  logic [p_num_reqs-1:0]         req_val,
  output logic [p_num_reqs-1:0]         req_rdy,
  output logic [7:0]                    ascii,
  output logic                          ascii_val,
  output logic [$clog2(p_num_reqs)-1:0] grant_id,
  output logic                          busy
);

  localparam int         IDX_W   = $clog2(p_num_reqs);
  localparam logic [15:0] TIMEOUT = 16'(p_timeout);
  localparam logic [p_num_reqs-1:0] RDY_ONE = {{(p_num_reqs - 1){1'b0}}, 1'b1};

  arb_state_e             state_r, state_s;
  logic [IDX_W-1:0]       ptr_r, grant_id_r, winner_s, next_ptr_s;
  logic [p_num_reqs-1:0]  req_rdy_r;
  logic [7:0]             ascii_r, chr_s;
  logic                   ascii_val_r, busy_r, any_val_s;
  logic                   xfer_s, eol_s, timeout_s;
  logic [15:0]            idle_cnt_r, cnt_inc_s;

  ascii_rr_picker #(
    .p_num_reqs (p_num_reqs),
    .p_idx_w    (IDX_W)
  ) u_picker (
    .req_val (req_val),
    .pointer (ptr_r),
    .winner  (winner_s),
    .any_val (any_val_s)
  );

  // Handshake, end-of-line and idle-timeout detection for the current holder.
  always_comb begin
    chr_s      = req_ascii[grant_id_r];
    xfer_s     = (state_r == ST_LOCKED) && req_val[grant_id_r] && req_rdy_r[grant_id_r];
    eol_s      = xfer_s && is_eol(chr_s);
    cnt_inc_s  = (idle_cnt_r == 16'hFFFF) ? idle_cnt_r : idle_cnt_r + 16'd1;
    timeout_s  = (state_r == ST_LOCKED) && !xfer_s && (cnt_inc_s >= TIMEOUT);
    next_ptr_s = (grant_id_r == IDX_W'(p_num_reqs - 1)) ? '0 : grant_id_r + IDX_W'(1);
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_val_s) begin
`ifdef ASCII_ARB_PREFIX_EN
          state_s = ST_PFX_ID;
`else
          state_s = ST_LOCKED;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef ASCII_ARB_PREFIX_EN
      ST_PFX_ID:    state_s = ST_PFX_COLON;
      ST_PFX_COLON: state_s = ST_LOCKED;
`endif
      ST_LOCKED: begin
        if (eol_s || timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, pointer, counter and all registered outputs; ready is loaded one
  // cycle ahead so it is high exactly while LOCKED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      grant_id_r  <= '0;
      idle_cnt_r  <= 16'd0;
      ascii_r     <= 8'h00;
      ascii_val_r <= 1'b0;
      busy_r      <= 1'b0;
      req_rdy_r   <= '0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != ST_IDLE);
      ascii_val_r <= 1'b0;
      req_rdy_r   <= '0;
      idle_cnt_r  <= 16'd0;
      case (state_r)
        ST_IDLE: begin
          if (any_val_s) begin
            grant_id_r  <= winner_s;
`ifdef ASCII_ARB_PREFIX_EN
            ascii_r     <= ASCII_ZERO + 8'(winner_s);
            ascii_val_r <= 1'b1;
`else
            req_rdy_r   <= RDY_ONE << winner_s;
`endif
          end else begin
            grant_id_r <= grant_id_r;
          end
        end
`ifdef ASCII_ARB_PREFIX_EN
        ST_PFX_ID: begin
          ascii_r     <= ASCII_COLON;
          ascii_val_r <= 1'b1;
        end
        ST_PFX_COLON: begin
          req_rdy_r <= RDY_ONE << grant_id_r;
        end
`endif
        ST_LOCKED: begin
          if (xfer_s) begin
            ascii_r     <= chr_s;
            ascii_val_r <= 1'b1;
          end else begin
            idle_cnt_r  <= cnt_inc_s;
          end
          if (eol_s || timeout_s) begin
            ptr_r <= next_ptr_s;
          end else begin
            req_rdy_r <= req_rdy_r;
          end
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  assign req_rdy   = req_rdy_r;
  assign ascii     = ascii_r;
  assign ascii_val = ascii_val_r;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;

endmodule

// File: doc/ascii_stream_arb.md
ASCII_STREAM_ARB -- requirements
Module: ascii_stream_arb

Interface
REQ-001 SHALL have parameter p_num_reqs, default 2, number of ASCII requesters (2..8).
REQ-002 SHALL have parameter p_timeout, default 255, idle cycles before a held grant is dropped (1..65535).
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_ascii, input, p_num_reqs x 8, per-requester character.
REQ-006 SHALL have port req_val, input, p_num_reqs, per-requester valid.
REQ-007 SHALL have port req_rdy, output, p_num_reqs, per-requester ready.
REQ-008 SHALL have port ascii, output, 8, character to the character buffer.
REQ-009 SHALL have port ascii_val, output, 1, character valid; the character buffer never backpressures.
REQ-010 SHALL have port grant_id, output, clog2(p_num_reqs), index of the current or most recent holder.
REQ-011 SHALL have port busy, output, 1, high while any state other than IDLE is active.

Function
REQ-012 SHALL implement states IDLE, PFX_ID, PFX_COLON and LOCKED; PFX states exist only per REQ-026.
REQ-013 IDLE: all req_rdy low; if any req_val is high, the block SHALL select a winner round-robin, starting at the priority pointer and searching upward with wrap.
REQ-014 IDLE: the block SHALL register the winner into grant_id and move to the next state in the following cycle.
REQ-015 LOCKED: req_rdy[grant_id] SHALL be high and all other req_rdy bits low; a transfer is req_val & req_rdy.
REQ-016 On a transfer, the block SHALL drive ascii = transferred character and ascii_val = 1 in the next cycle (1-cycle registered latency); otherwise ascii_val SHALL be 0.
REQ-017 Characters SHALL pass through unmodified, including DEL (8'h7F).
REQ-018 A transfer of LF (8'h0A) or ESC (8'h1B) SHALL end the lock: next state IDLE, priority pointer = grant_id+1 modulo p_num_reqs.
REQ-019 An idle counter SHALL clear on each transfer and increment in LOCKED cycles without req_val[grant_id]; reaching p_timeout SHALL move the state to IDLE with the pointer advanced as in REQ-018.
REQ-020 After a lock ends, at least one IDLE cycle SHALL occur before the next grant; requesters SHALL never interleave within a line.
REQ-021 The block SHALL ignore req_val and req_ascii of non-granted requesters and never emit them.
REQ-022 grant_id SHALL hold its value in IDLE until a new grant is made.
REQ-023 The counter SHALL be 16 bits and saturate; the pointer SHALL wrap from p_num_reqs-1 to 0.

Reset
REQ-024 During rst, the block SHALL go to state IDLE with pointer=0, grant_id=0, counter=0, ascii=8'h00, ascii_val=0, busy=0 and all req_rdy=0.
REQ-025 An rst asserted mid-line SHALL drop the lock with no partial prefix or character emitted in the cycle after rst.

Configuration
REQ-026 With ASCII_ARB_PREFIX_EN defined, a new grant SHALL go IDLE->PFX_ID->PFX_COLON->LOCKED, emitting ascii=8'h30+grant_id in PFX_ID and 8'h3A (':') in PFX_COLON, each with ascii_val=1 and all req_rdy low.
REQ-027 Without ASCII_ARB_PREFIX_EN, the PFX states and their logic SHALL be absent and IDLE SHALL go directly to LOCKED.

Structure
REQ-028 Package ascii_arb_pkg SHALL hold the state enum and the constants ASCII_LF, ASCII_ESC, ASCII_DEL, ASCII_ZERO (8'h30) and ASCII_COLON (8'h3A).
REQ-029 Sub-module ascii_rr_picker SHALL hold the combinational round-robin selection: inputs req_val and pointer; outputs winner index and any_val.

Verification
REQ-030 req0 sends "A","B",LF, then req1 sends "C": output A,B,LF, then C; grant_id 0 then 1; C appears at least 2 cycles after LF.
REQ-031 req0 and req1 both valid continuously from reset: req0 wins first; after req0's LF, req1 wins (pointer=1).
REQ-032 With p_timeout=4, req0 sends "X" then drops val: the lock is released 4 cycles later and busy falls; a pending req1 is then granted.
REQ-033 req1 is granted and sends ESC (8'h1B): ESC is emitted, state returns to IDLE and the pointer becomes 0 (with p_num_reqs=2).
REQ-034 With ASCII_ARB_PREFIX_EN and a grant to req1: output sequence 8'h31, 8'h3A, then req1's characters; req_rdy[1] stays low for the 2 prefix cycles.
REQ-035 rst is asserted while req0 is mid-line: the next cycle shows ascii_val=0 and busy=0, and grant restarts from pointer 0.
